// File: rtl/funcs_sched_if.sv
// Bundle of request, shared function-unit and response signals for funcs_sched.
// The slave modport is the scheduler; the master modport is whoever drives requests and hosts the unit.
interface funcs_sched_if #(
    parameter int N  = 4,
    parameter int CW = 32
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [2*N-1:0]     req_op;
    logic [128*N-1:0]   req_data;

    logic [7:0]         fu_a;
    logic [7:0]         fu_b;
    logic [127:0]       fu_e;
    logic [7:0]         fu_c;
    logic [7:0]         fu_d;
    logic [127:0]       fu_f;
    logic [127:0]       fu_g;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [127:0]       resp_data;
    logic [CW-1:0]      op_count;

    modport slave (
        input  req_valid, req_op, req_data, fu_c, fu_d, fu_f, fu_g, resp_ready,
        output req_ready, fu_a, fu_b, fu_e, resp_valid, resp_id, resp_data, op_count
    );

    modport master (
        output req_valid, req_op, req_data, fu_c, fu_d, fu_f, fu_g, resp_ready,
        input  req_ready, fu_a, fu_b, fu_e, resp_valid, resp_id, resp_data, op_count
    );
endinterface

// File: rtl/funcs_sched.sv
// Round-robin scheduler sharing one combinational function unit among N requesters.
// Two single-entry stages (ISSUE drives the unit, RESP holds the tagged result).
module funcs_sched #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N),
    parameter int CW  = 32
) (
    input logic         clk,
    input logic         rst,
    funcs_sched_if.slave bus
);
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_PASS = 2'd2,
        OP_INV  = 2'd3
    } op_e;

    logic           issue_valid;
    op_e            issue_op;
    logic [IDW-1:0] issue_id;
    logic [127:0]   issue_data;

    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic [127:0]   resp_data_q;
    logic [CW-1:0]  op_count_q;
    logic [IDW-1:0] ptr;

    logic           resp_move;
    logic           issue_move;
    logic           can_accept;
    logic           accept;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic [N-1:0]   grant_oh;
    logic [127:0]   result;

    assign resp_move  = ~resp_valid_q | bus.resp_ready;
    assign issue_move = issue_valid & resp_move;
    assign can_accept = ~issue_valid | issue_move;
    assign accept     = grant_any & can_accept & ~rst;

    // Scan starts just after the last accepted index, so a stalled grant keeps its place.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_oh  = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = IDW'((int'(ptr) + k) % N);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    assign bus.req_ready = grant_oh & {N{can_accept & ~rst}};

    always_comb begin
        bus.fu_a = '0;
        bus.fu_b = '0;
        bus.fu_e = '0;
        result   = '0;
        if (issue_valid) begin
            case (issue_op)
                OP_ADD:  begin bus.fu_a = issue_data[7:0]; result = {120'b0, bus.fu_c}; end
                OP_SUB:  begin bus.fu_b = issue_data[7:0]; result = {120'b0, bus.fu_d}; end
                OP_PASS: begin bus.fu_e = issue_data;      result = bus.fu_f;           end
                OP_INV:  begin bus.fu_e = issue_data;      result = bus.fu_g;           end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload flops are reset along with the valids so resp_data reads zero out of reset; none of this is a RAM.
            issue_valid  <= 1'b0;
            issue_op     <= OP_ADD;
            issue_id     <= '0;
            issue_data   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            op_count_q   <= '0;
            ptr          <= IDW'(N - 1);
        end else begin
            // NOTE: non-blocking assignments here, so every stage reads the pre-edge values of the others.
            if (resp_move) begin
                resp_valid_q <= issue_valid;
                if (issue_valid) begin
                    resp_id_q   <= issue_id;
                    resp_data_q <= result;
                end
            end
            if (resp_valid_q && bus.resp_ready) op_count_q <= op_count_q + CW'(1);
            if (can_accept) issue_valid <= accept;
            if (accept) begin
                issue_op   <= op_e'(bus.req_op[{grant_idx, 1'b0} +: 2]);
                issue_id   <= grant_idx;
                issue_data <= bus.req_data[{grant_idx, 7'b0} +: 128];
                ptr        <= grant_idx;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_funcs_sched.sv
// Self-checking bench for funcs_sched: directed scenarios plus a random phase, all
// checked against a transaction-level model (in-flight list with ages, RR pointer).
module tb_funcs_sched;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    funcs_sched_if #(.N(N), .CW(CW)) bus ();

    funcs_sched #(.N(N), .IDW(IDW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural function unit
    assign bus.fu_c = bus.fu_a + 8'd12;
    assign bus.fu_d = bus.fu_b - 8'd34;
    assign bus.fu_f = bus.fu_e;
    assign bus.fu_g = ~bus.fu_e;

    typedef struct {
        int           id;
        logic [127:0] data;
        int           age;
    } txn_t;

    txn_t          pipe[$];
    int            m_ptr;
    logic [CW-1:0] m_count;
    int            acc_log[$];
    bit            hold_valid;
    int            checks = 0;
    int            errors = 0;
    logic [IDW-1:0] saved_id;
    logic [127:0]   saved_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_result(input logic [1:0] op, input logic [127:0] d);
        logic [7:0] lo;
        lo = d[7:0];
        case (op)
            2'd0:    return {120'b0, 8'((int'(lo) + 12) % 256)};
            2'd1:    return {120'b0, 8'((int'(lo) - 34 + 256) % 256)};
            2'd2:    return d;
            default: return ~d;
        endcase
    endfunction

    function automatic int exp_grant();
        for (int k = 1; k <= N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Oldest op is visible two edges after its accept; at most two ops in flight.
    function automatic bit exp_valid();
        return pipe.size() > 0 && pipe[0].age >= 2;
    endfunction

    function automatic bit exp_can();
        return pipe.size() < 2 || bus.resp_ready;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int           g;
        bit           acc;
        bit           pop;
        logic [N-1:0] exp_ready;
        logic [1:0]   op_s;
        logic [127:0] data_s;
        #1;
        g   = exp_grant();
        acc = !rst && g >= 0 && exp_can();
        exp_ready = acc ? (N'(1) << g) : '0;
        check("req_ready", bus.req_ready, exp_ready);
        check("resp_valid", bus.resp_valid, exp_valid());
        if (exp_valid()) begin
            check("resp_id", bus.resp_id, pipe[0].id);
            check("resp_data", bus.resp_data, pipe[0].data);
        end
        check("op_count", bus.op_count, m_count);
        for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) acc_log.push_back(i);
        if (acc) begin
            op_s   = bus.req_op[2*g +: 2];
            data_s = bus.req_data[128*g +: 128];
        end
        pop = exp_valid() && bus.resp_ready;
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            m_ptr   = N - 1;
            m_count = '0;
        end else begin
            if (pop) begin
                void'(pipe.pop_front());
                m_count++;
            end
            foreach (pipe[j]) pipe[j].age++;
            if (acc) begin
                pipe.push_back('{id: g, data: ref_result(op_s, data_s), age: 1});
                m_ptr = g;
            end
        end
        @(negedge clk);
        if (acc && !rst && !hold_valid) bus.req_valid[g] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [127:0] d);
        bus.req_op[2*i +: 2]       = op;
        bus.req_data[128*i +: 128] = d;
        bus.req_valid[i]           = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        hold_valid     = 1'b0;
        m_ptr          = N - 1;
        m_count        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with requests pending while reset is high
        bus.req_valid = '1;
        #1;
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_fu_a", bus.fu_a, 0);
        check("rst_fu_b", bus.fu_b, 0);
        check("rst_fu_e", bus.fu_e, 0);
        check("rst_op_count", bus.op_count, 0);
        check("rst_req_ready", bus.req_ready, 0);
        step();
        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;

        // Req0 ADD 0x05: two-cycle latency, 0x11
        set_req(0, 2'd0, 128'h05);
        step();
        step();
        #1;
        check("add_valid", bus.resp_valid, 1);
        check("add_id", bus.resp_id, 0);
        check("add_data", bus.resp_data, 128'h11);
        step();
        #1 check("add_count", bus.op_count, 1);

        // Req1 SUB 0x10 and req2 INV 0 back to back
        set_req(1, 2'd1, 128'h10);
        set_req(2, 2'd3, 128'h0);
        step();
        step();
        #1;
        check("sub_id", bus.resp_id, 1);
        check("sub_data", bus.resp_data, 128'hEE);
        step();
        #1;
        check("inv_id", bus.resp_id, 2);
        check("inv_data", bus.resp_data, {128{1'b1}});
        step();

        // Grant to req0, then only req3: wrap-around scan picks req3
        set_req(0, 2'd2, 128'h5A);
        step();
        set_req(3, 2'd2, 128'h3C);
        acc_log.delete();
        step();
        check("wrap_cnt", acc_log.size(), 1);
        if (acc_log.size() > 0) check("wrap_id", acc_log[0], 3);

        // All valid, PASS operand = id: order 0,1,2,3,0,1
        for (int i = 0; i < N; i++) set_req(i, 2'd2, 128'(i));
        hold_valid = 1'b1;
        acc_log.delete();
        repeat (6) step();
        check("rr_cnt", acc_log.size(), 6);
        for (int k = 0; k < 6 && k < acc_log.size(); k++) check("rr_order", acc_log[k], k % N);
        hold_valid    = 1'b0;
        bus.req_valid = '0;
        repeat (3) step();

        // Stall: resp_ready low for 5 cycles with all requesters valid
        for (int i = 0; i < N; i++) set_req(i, 2'd3, 128'(i * 7 + 1));
        hold_valid     = 1'b1;
        bus.resp_ready = 1'b0;
        acc_log.delete();
        for (int s = 0; s < 5; s++) begin
            if (s >= 2) begin
                #1;
                check("stall_valid", bus.resp_valid, 1);
                if (s == 2) begin
                    saved_id   = bus.resp_id;
                    saved_data = bus.resp_data;
                end else begin
                    check("stall_id", bus.resp_id, saved_id);
                    check("stall_data", bus.resp_data, saved_data);
                end
            end
            step();
        end
        check("stall_accepts", acc_log.size(), 2);
        hold_valid     = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (4) step();
        check("stall_drained", pipe.size(), 0);

        // Reset with both stages full
        bus.req_valid  = '1;
        hold_valid     = 1'b1;
        bus.resp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.req_valid = '0;
        #1;
        check("rst2_resp_valid", bus.resp_valid, 0);
        check("rst2_op_count", bus.op_count, 0);
        check("rst2_req_ready", bus.req_ready, 0);
        step();
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        acc_log.delete();
        step();
        check("rst2_first_cnt", acc_log.size(), 1);
        if (acc_log.size() > 0) check("rst2_first_id", acc_log[0], 0);
        hold_valid    = 1'b0;
        bus.req_valid = '0;

        // Random traffic: random ops/data (changing while pending), random backpressure
        for (int c = 0; c < 400; c++) begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_op[2*i +: 2]       = 2'($urandom_range(0, 3));
                    bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) bus.req_valid[i] = 1'b1;
            end
            step();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (5) step();
        check("final_drained", pipe.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/funcs_sched.md
Name: funcs_sched

Overview:
- Round-robin scheduler that shares one combinational function unit among N requesters.
- The unit computes c=a+12, d=b-34, f=e and g=~e.
- Each requester submits an opcode and a 128-bit operand through a valid/ready handshake. The block issues one operation per cycle to the shared unit, captures the selected result, and returns it tagged with the requester ID.
- Sits between the UMI-to-GPIO request demux and the function-unit instance.

Parameters:
N, 4, number of requesters (2..16)
IDW, $clog2(N), width of requester ID
CW, 32, completed-operation counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  N  per-requester request valid
req_ready  output  N  per-requester ready (one-hot or zero)
req_op  input  2*N  per-requester opcode, slice i = [2i+1:2i]; 0=ADD, 1=SUB, 2=PASS, 3=INV
req_data  input  128*N  per-requester operand, slice i = [128i+127:128i]
fu_a  output  8  shared unit input a
fu_b  output  8  shared unit input b
fu_e  output  128  shared unit input e
fu_c  input  8  shared unit result a+12
fu_d  input  8  shared unit result b-34
fu_f  input  128  shared unit result e
fu_g  input  128  shared unit result ~e
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  IDW  requester index of response
resp_data  output  128  result
op_count  output  CW  number of responses accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - resp_valid=0, resp_id=0, resp_data=0, fu_a=fu_b=0, fu_e=0, op_count=0.
  - Issue stage empty; RR pointer=N-1, so requester 0 has highest priority first.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards in-flight ops without emitting responses.
- Pipeline: two single-entry registers, ISSUE then RESP.
  - Request accepted at edge T (req_valid[i]&req_ready[i]).
  - ISSUE holds {op,id,operand} during cycle T+1 and drives fu_*.
  - Result captured into RESP at edge T+1; resp_valid=1 in cycle T+2.
  - Minimum latency is 2 cycles. Throughput is 1 op/cycle with resp_ready held high.
- Function-unit drive from ISSUE:
  - fu_a = operand[7:0] when op=ADD, else 0.
  - fu_b = operand[7:0] when op=SUB, else 0.
  - fu_e = operand when op is PASS or INV, else 0.
  - When ISSUE is empty, all fu_* = 0.
- Result select:
  - ADD -> {120'b0, fu_c}; SUB -> {120'b0, fu_d}; PASS -> fu_f; INV -> fu_g.
  - 8-bit arithmetic wraps modulo 256.
- Flow control:
  - resp_move = ~resp_valid | resp_ready.
  - issue_move = ISSUE valid & resp_move.
  - can_accept = ~ISSUE valid | issue_move.
  - If resp_ready=1 with resp_valid=1 and ISSUE is empty, resp_valid drops the next cycle.
- Arbitration:
  - Combinational. Grant goes to the first i with req_valid[i]=1, scanning from (ptr+1) mod N upward with wrap-around.
  - req_ready = grant one-hot AND can_accept. It depends on req_valid and is never asserted for a non-valid requester.
  - ptr updates to the granted index only on accept. Without an accept, ptr holds, so a stalled grant keeps its priority.
  - No requester waits more than N-1 accepts.
- Requesters may change req_op/req_data while not accepted. Values are sampled only at the accept edge.
- Simultaneous events:
  - RESP is consumed and ISSUE advances in the same edge: both happen, and a new accept may also occur in that edge.
  - Full pipeline (ISSUE valid, RESP valid, resp_ready=0): req_ready=0.
- op_count increments on each resp_valid&resp_ready edge and wraps at 2^CW.

Test Plan:
- Req0 ADD, operand 0x05, resp_ready=1 -> resp_valid 2 cycles after accept; resp_id=0; resp_data=0x11, upper 120 bits zero; op_count=1.
- Req1 SUB 0x10 and req2 INV 0x0 issued back-to-back -> responses on consecutive cycles: (id1, 0xEE), then (id2, all-ones).
- All 4 requesters valid continuously with op PASS and operand = id -> accept order 0,1,2,3,0,1; resp_data matches id; one response per cycle.
- resp_ready=0 for 5 cycles with all requesters valid:
  - exactly 2 accepts, then req_ready=0;
  - resp_valid held with stable resp_id/resp_data;
  - on release, responses drain in order with none lost or duplicated.
- Only req3 valid after a grant to req0 -> req3 granted immediately (wrap scan), then ptr=3, so req0 has priority next.
- rst asserted for 1 cycle with both stages full -> next cycle resp_valid=0, op_count=0, req_ready=0; first grant afterwards goes to req0.
